// File: rtl/ysyx_24080006_mdu_iter.sv
// Iterative RV M-extension multiply/divide unit with valid/ready handshakes and flush.
// Optional operand/result reuse cache is enabled by defining YSYX_24080006_MDU_FUSE_EN.
module ysyx_24080006_mdu_iter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            kill,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ABS  = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [XLEN-1:0]  XMIN     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  XONES    = {XLEN{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);

    // Result select shared by the normal path and the reuse cache (hi = product hi / remainder).
    function automatic logic [XLEN-1:0] sel_res(input logic [2:0] op,
                                                 input logic [XLEN-1:0] hi,
                                                 input logic [XLEN-1:0] lo);
        if (op[2])
            sel_res = op[1] ? hi : lo;
        else
            sel_res = (op[1:0] == 2'b00) ? lo : hi;
    endfunction

    logic [2:0]        state_q, state_d;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN:0]     rem_q;
    logic [XLEN-1:0]   dvs_q;
    logic              qneg_q, rneg_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept_c, div0_c, ovf_c, fast_c, hit_c;
    logic [XLEN-1:0]   fast_res_c, load_res_c;

    assign accept_c   = in_valid & in_ready & ~kill;
    assign div0_c     = in_op[2] & (in_b == '0);
    assign ovf_c      = in_op[2] & ~in_op[0] & (in_a == XMIN) & (in_b == XONES);
    assign fast_c     = div0_c | ovf_c;
    assign fast_res_c = div0_c ? (in_op[1] ? in_a : XONES) : (in_op[1] ? '0 : XMIN);

    // Operand signedness by op: MULHU/DIVU/REMU unsigned, MULHSU signs only rs1.
    logic            a_signed_c, b_signed_c, a_neg_c, b_neg_c;
    logic [XLEN-1:0] a_mag_c, b_mag_c;

    assign a_signed_c = op_q[2] ? ~op_q[0] : (op_q[1:0] != 2'b11);
    assign b_signed_c = op_q[2] ? ~op_q[0] : ~op_q[1];
    assign a_neg_c    = a_signed_c & a_q[XLEN-1];
    assign b_neg_c    = b_signed_c & b_q[XLEN-1];
    assign a_mag_c    = a_neg_c ? -a_q : a_q;
    assign b_mag_c    = b_neg_c ? -b_q : b_q;

    logic [XLEN:0]     mul_sum_c;
    logic [2*XLEN-1:0] mul_next_c, div_next_c;
    logic              ge_c;
    logic [XLEN-1:0]   rem_sub_c;

    assign mul_sum_c  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, dvs_q} : {(XLEN+1){1'b0}});
    assign mul_next_c = {mul_sum_c, prod_q[XLEN-1:1]};
    assign ge_c       = rem_q >= {1'b0, dvs_q};
    assign rem_sub_c  = ge_c ? XLEN'(rem_q - {1'b0, dvs_q}) : rem_q[XLEN-1:0];
    assign div_next_c = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-2:0], ge_c};

    logic [2*XLEN-1:0] prod_fix_c;
    logic [XLEN-1:0]   quo_fix_c, rem_fix_c, fix_hi_c, fix_lo_c;

    assign prod_fix_c = qneg_q ? -prod_q : prod_q;
    assign quo_fix_c  = qneg_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
    assign rem_fix_c  = rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    assign fix_hi_c   = op_q[2] ? rem_fix_c : prod_fix_c[2*XLEN-1:XLEN];
    assign fix_lo_c   = op_q[2] ? quo_fix_c : prod_fix_c[XLEN-1:0];

`ifdef YSYX_24080006_MDU_FUSE_EN
    // MUL computes signed*signed, so it shares a tag with MULH.
    function automatic logic [1:0] sign_tag(input logic [2:0] op);
        if (op[2])
            sign_tag = {1'b0, op[0]};
        else if (op[1:0] == 2'b00)
            sign_tag = 2'b01;
        else
            sign_tag = op[1:0];
    endfunction

    logic            cache_vld_q, cache_div_q;
    logic [1:0]      cache_tag_q;
    logic [XLEN-1:0] cache_a_q, cache_b_q, cache_hi_q, cache_lo_q;
    logic [XLEN-1:0] hit_res_c;

    assign hit_c = cache_vld_q & (cache_div_q == in_op[2]) & (cache_a_q == in_a) &
                   (cache_b_q == in_b) &
                   ((cache_tag_q == sign_tag(in_op)) | (in_op == 3'b000));
    assign hit_res_c  = sel_res(in_op, cache_hi_q, cache_lo_q);
    assign load_res_c = fast_c ? fast_res_c : hit_res_c;

    // Filled on completion; dropped by flush or by any accepted miss.
    always_ff @(posedge clock) begin
        if (reset) begin
            cache_vld_q <= 1'b0;
            cache_div_q <= 1'b0;
            cache_tag_q <= '0;
            cache_a_q   <= '0;
            cache_b_q   <= '0;
            cache_hi_q  <= '0;
            cache_lo_q  <= '0;
        end else if (kill) begin
            cache_vld_q <= 1'b0;
        end else if (state_q == S_FIX) begin
            cache_vld_q <= 1'b1;
            cache_div_q <= op_q[2];
            cache_tag_q <= sign_tag(op_q);
            cache_a_q   <= a_q;
            cache_b_q   <= b_q;
            cache_hi_q  <= fix_hi_c;
            cache_lo_q  <= fix_lo_c;
        end else if (accept_c & ~hit_c) begin
            cache_vld_q <= 1'b0;
        end
    end
`else
    assign hit_c      = 1'b0;
    assign load_res_c = fast_res_c;
`endif

    // Next-state logic; kill overrides everything.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept_c) state_d = (fast_c | hit_c) ? S_DONE : S_ABS;
            S_ABS:  state_d = S_CALC;
            S_CALC: if (cnt_q == '0) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (kill) state_d = S_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            prod_q     <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == S_IDLE);
            out_valid <= (state_d == S_DONE);
            if (accept_c) begin
                op_q <= in_op;
                a_q  <= in_a;
                b_q  <= in_b;
                if (fast_c | hit_c) out_result <= load_res_c;
            end
            unique case (state_q)
                S_ABS: begin
                    prod_q <= {{XLEN{1'b0}}, a_mag_c};
                    rem_q  <= {{XLEN{1'b0}}, a_mag_c[XLEN-1]};
                    dvs_q  <= b_mag_c;
                    qneg_q <= a_neg_c ^ b_neg_c;
                    rneg_q <= a_neg_c;
                    cnt_q  <= CNT_LAST;
                end
                S_CALC: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (op_q[2]) begin
                        prod_q <= div_next_c;
                        // Last step keeps the unshifted remainder.
                        rem_q  <= (cnt_q == '0) ? {1'b0, rem_sub_c} : {rem_sub_c, prod_q[XLEN-2]};
                    end else begin
                        prod_q <= mul_next_c;
                    end
                end
                S_FIX: out_result <= sel_res(op_q, fix_hi_c, fix_lo_c);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24080006_mdu_iter.sv
// Self-checking bench for ysyx_24080006_mdu_iter: vector table through a result scoreboard,
// plus backpressure, kill and reuse-cache sequences. Latencies adapt to YSYX_24080006_MDU_FUSE_EN.
module tb_ysyx_24080006_mdu_iter;

    localparam int unsigned XLEN = 32;
    localparam int LAT = XLEN + 3;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    logic            clock = 1'b0;
    logic            reset, kill, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]      in_op;
    logic [XLEN-1:0] in_a, in_b, out_result;

    int n_cmp = 0;
    int n_bad = 0;
    logic [XLEN-1:0] exp_q[$];

    typedef struct {
        logic [2:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
        int              lat_plain;
        int              lat_fuse;
    } vec_t;
    vec_t vecs[$];

    ysyx_24080006_mdu_iter #(.XLEN(XLEN)) dut (
        .clock      (clock),
        .reset      (reset),
        .kill       (kill),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Drive one request for one edge; caller is #1 past a rising edge.
    task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] exp, input string name);
        check({name, "_in_ready"}, XLEN'(in_ready), XLEN'(1));
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_op    = 3'($urandom);
        in_a     = $urandom;
        in_b     = $urandom;
        exp_q.push_back(exp);
    endtask

    task automatic wait_result(input int exp_lat, input string name);
        int lat;
        logic [XLEN-1:0] exp;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check({name, "_latency"}, XLEN'(lat), XLEN'(exp_lat));
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: result with empty scoreboard", name);
        end else begin
            exp = exp_q.pop_front();
            check({name, "_result"}, out_result, exp);
        end
    endtask

    task automatic release_result(input string name);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check({name, "_ready_after"}, XLEN'(in_ready), XLEN'(1));
        check({name, "_valid_after"}, XLEN'(out_valid), XLEN'(0));
    endtask

    function automatic int pick_lat(input int plain, input int fuse);
`ifdef YSYX_24080006_MDU_FUSE_EN
        pick_lat = fuse;
`else
        pick_lat = plain;
`endif
    endfunction

    initial begin
        logic seen;
        logic [XLEN-1:0] held;
        string nm;

        vecs.push_back('{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, LAT, LAT});
        vecs.push_back('{OP_MUL,    32'h80000000, 32'h80000000, 32'h00000000, LAT, 1});
        vecs.push_back('{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT, LAT});
        vecs.push_back('{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT, LAT});
        vecs.push_back('{OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, LAT, 1});
        vecs.push_back('{OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, LAT, LAT});
        vecs.push_back('{OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, LAT, 1});
        vecs.push_back('{OP_DIVU,   32'd100,      32'd7,        32'd14,       LAT, LAT});
        vecs.push_back('{OP_REMU,   32'd100,      32'd7,        32'd2,        LAT, 1});
        vecs.push_back('{OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1,   1});
        vecs.push_back('{OP_REM,    32'd5,        32'd0,        32'd5,        1,   1});
        vecs.push_back('{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,   1});
        vecs.push_back('{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,   1});
        vecs.push_back('{OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT, LAT});
        vecs.push_back('{OP_MULH,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, LAT, 1});
        vecs.push_back('{OP_DIV,    32'h80000000, 32'h00000001, 32'h80000000, LAT, LAT});
        vecs.push_back('{OP_REM,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, LAT, LAT});
        vecs.push_back('{OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, LAT, LAT});
        vecs.push_back('{OP_DIV,    32'd100,      32'd7,        32'd14,       LAT, LAT});
        vecs.push_back('{OP_REM,    32'd100,      32'd7,        32'd2,        LAT, 1});
        vecs.push_back('{OP_REM,    32'd100,      32'd8,        32'd4,        LAT, LAT});

        reset = 1'b1; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_a = '0; in_b = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_in_ready", XLEN'(in_ready), XLEN'(1));
        check("reset_out_valid", XLEN'(out_valid), XLEN'(0));
        check("reset_out_result", out_result, '0);

        foreach (vecs[i]) begin
            nm = $sformatf("vec%0d", i);
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, nm);
            wait_result(pick_lat(vecs[i].lat_plain, vecs[i].lat_fuse), nm);
            release_result(nm);
        end

        // Backpressure: result held stable, no new request taken.
        issue(OP_DIVU, 32'd1000, 32'd3, 32'd333, "bp");
        wait_result(LAT, "bp");
        held = out_result;
        for (int k = 0; k < 10; k++) begin
            @(posedge clock);
            #1;
            check($sformatf("bp_hold%0d_result", k), out_result, 32'd333);
            check($sformatf("bp_hold%0d_in_ready", k), XLEN'(in_ready), XLEN'(0));
        end
        // Output handshake with a concurrent request: the request is ignored.
        in_op = OP_REMU; in_a = 32'd1000; in_b = 32'd3; in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("collide_in_ready", XLEN'(in_ready), XLEN'(1));
        check("collide_out_valid", XLEN'(out_valid), XLEN'(0));

        // Kill on the same edge as a request blocks acceptance.
        in_op = OP_MUL; in_a = 32'd9; in_b = 32'd9; in_valid = 1'b1; kill = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0; kill = 1'b0;
        check("kill_accept_in_ready", XLEN'(in_ready), XLEN'(1));

        // Kill during the fifth CALC cycle discards the operation.
        issue(OP_DIV, 32'd1000, 32'hFFFFFFFD, 32'hFFFFFEB3, "kcalc");
        void'(exp_q.pop_front());
        repeat (5) begin
            @(posedge clock);
            #1;
        end
        kill = 1'b1;
        @(posedge clock);
        #1;
        kill = 1'b0;
        check("kcalc_in_ready", XLEN'(in_ready), XLEN'(1));
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clock);
            #1;
        end
        check("kcalc_no_valid", XLEN'(seen), XLEN'(0));
        issue(OP_MUL, 32'd3, 32'd4, 32'd12, "after_kill");
        wait_result(LAT, "after_kill");
        release_result("after_kill");

        // Kill in DONE drops the result despite out_ready, and clears any reuse state.
        issue(OP_DIVU, 32'd100, 32'd7, 32'd14, "kdone");
        wait_result(LAT, "kdone");
        kill = 1'b1; out_ready = 1'b1;
        @(posedge clock);
        #1;
        kill = 1'b0; out_ready = 1'b0;
        check("kdone_out_valid", XLEN'(out_valid), XLEN'(0));
        check("kdone_in_ready", XLEN'(in_ready), XLEN'(1));
        issue(OP_REMU, 32'd100, 32'd7, 32'd2, "post_kdone");
        wait_result(LAT, "post_kdone");
        release_result("post_kdone");

        check("scoreboard_empty", XLEN'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
